// File: rtl/stack_cmd_if.sv
// Button-to-stack command bus: debounced levels and stack flags in, strobes out.
interface stack_cmd_if;
   logic push_lvl;
   logic pop_lvl;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic reject;

   // Side that owns the buttons and the stack (drives levels and flags)
   modport master (
      output push_lvl, pop_lvl, full, empty,
      input  push, pop, reject
   );

   // Command generator side
   modport slave (
      input  push_lvl, pop_lvl, full, empty,
      output push, pop, reject
   );
endinterface

// File: rtl/stack_cmd_gen.sv
// Turns debounced push/pop button levels into single-cycle, auto-repeating,
// overflow/underflow-guarded stack strobes. Push and pop never share a cycle.
//
// state  | meaning
// IDLE   | button released (or held since before reset); waiting for a rising level
// FIRST  | first strobe issued; counting the initial hold delay
// REPEAT | counting the interval between auto-repeat strobes
module stack_cmd_gen #(
   parameter int DELAY_CYCLES  = 6_000_000,
   parameter int REPEAT_CYCLES = 1_200_000,
   parameter int CNT_W         = 23
) (
   input  logic        clk,
   input  logic        reset,
   stack_cmd_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FIRST, REPEAT} ch_state_t;

   localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_TC = CNT_W'(REPEAT_CYCLES - 1);

   // index 0 = push channel, index 1 = pop channel
   ch_state_t        st_q  [2];
   ch_state_t        st_d  [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       lvl;
   logic [1:0]       prev_q;
   logic [1:0]       req;

   logic pend_q, pend_d;
   logic push_d, pop_d, rej_d;

   assign lvl = {bus.pop_lvl, bus.push_lvl};

   // Channel state, hold counters and previous-level copies.
   // prev resets to 1 so a button held through reset needs a fresh press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
         prev_q <= 2'b11;
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         prev_q <= lvl;
      end
   end

   // Channel next-state: raise a request on press, after the first delay,
   // and on every repeat interval; release always returns to IDLE.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         req[i]   = 1'b0;
         case (st_q[i])
            IDLE: begin
               if (lvl[i] && !prev_q[i]) begin
                  req[i]   = 1'b1;
                  cnt_d[i] = '0;
                  st_d[i]  = FIRST;
               end
            end
            FIRST: begin
               if (!lvl[i]) begin
                  cnt_d[i] = '0;
                  st_d[i]  = IDLE;
               end else if (cnt_q[i] == DLY_TC) begin
                  req[i]   = 1'b1;
                  cnt_d[i] = '0;
                  st_d[i]  = REPEAT;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            REPEAT: begin
               if (!lvl[i]) begin
                  cnt_d[i] = '0;
                  st_d[i]  = IDLE;
               end else if (cnt_q[i] == RPT_TC) begin
                  req[i]   = 1'b1;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               cnt_d[i] = '0;
               st_d[i]  = IDLE;
            end
         endcase
      end
   end

   // Arbitration: push wins a collision and the pop is deferred one cycle;
   // full/empty are judged only in the cycle the strobe would be issued.
   always_comb begin
      push_d = 1'b0;
      pop_d  = 1'b0;
      rej_d  = 1'b0;
      pend_d = 1'b0;
      if (req[0]) begin
         if (!bus.full) push_d = 1'b1;
         else           rej_d  = 1'b1;
         pend_d = req[1] | pend_q;
      end else if (pend_q) begin
         if (!bus.empty) pop_d = 1'b1;
         else            rej_d = 1'b1;
         pend_d = req[1];
      end else if (req[1]) begin
         if (!bus.empty) pop_d = 1'b1;
         else            rej_d = 1'b1;
      end
   end

   // Registered strobes and the one-deep pending-pop flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.push   <= 1'b0;
         bus.pop    <= 1'b0;
         bus.reject <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         bus.push   <= push_d;
         bus.pop    <= pop_d;
         bus.reject <= rej_d;
         pend_q     <= pend_d;
      end
   end

endmodule

// File: doc/stack_cmd_gen.md
# stack_cmd_gen

Command generator between the two button Debounce instances and the Stack in the stack test top. It turns debounced push/pop button levels into single-cycle push/pop strobes. Holding a button auto-repeats the strobe. Requests that would overflow or underflow the stack are blocked and flagged. Simultaneous push/pop requests are serialised so the stack never sees both strobes in the same cycle.

## Interface
- DELAY_CYCLES, 6_000_000: clocks from the first strobe of a held button to its first repeat (0.5 s at 12 MHz); must be ≥2.
- REPEAT_CYCLES, 1_200_000: clocks between later repeats (0.1 s at 12 MHz); must be ≥2.
- CNT_W, 23: hold-counter width; 2^CNT_W must exceed max(DELAY_CYCLES, REPEAT_CYCLES).
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- push_lvl  input  1  debounced push button level, active-high.
- pop_lvl  input  1  debounced pop button level, active-high.
- full  input  1  stack full flag.
- empty  input  1  stack empty flag.
- push  output  1  one-cycle push strobe to the stack.
- pop  output  1  one-cycle pop strobe to the stack.
- reject  output  1  one-cycle pulse when a request is blocked by full or empty.

## Operation
- Two identical channel FSMs, one for push and one for pop. Each has a private hold counter and a registered copy of the previous level.
- Channel states:
  - IDLE to FIRST on a rising level (lvl=1, prev=0). Raises a request and clears the counter.
  - FIRST: counter increments each clock. When it reaches DELAY_CYCLES-1, raises a request, clears the counter and goes to REPEAT.
  - REPEAT: when the counter reaches REPEAT_CYCLES-1, raises a request and clears the counter.
  - FIRST or REPEAT to IDLE in the cycle lvl is sampled 0. No request is raised and the counter is cleared.
- Arbitration of the requests raised in a cycle:
  - Push request only: push strobe if full=0, otherwise a reject pulse.
  - Pop request only: pop strobe if empty=0, otherwise a reject pulse.
  - Both requests: push is handled as above, and the pop request is latched into a one-deep pending flag.
  - Pending pop: handled in the next cycle against the empty value of that cycle, then cleared. It is evaluated even if pop_lvl has since dropped.
- full and empty are sampled in the arbitration cycle only; a strobe is never issued speculatively.
- push and pop are never high in the same cycle.
- reject is never high in a cycle where push or pop is high for the same request.

## Timing
- All outputs are registered.
- A rising edge sampled at clock edge n gives push, pop or reject high during the cycle after edge n, for exactly one cycle.
- A deferred pop appears one cycle after the push it collided with.
- Held button: first strobe at cycle t. Repeats at t+DELAY_CYCLES, then every REPEAT_CYCLES, while the level stays 1.
- Reset (asynchronous, any time):
  - push=0, pop=0, reject=0.
  - Both channels IDLE, counters 0, pending flag 0.
  - prev registers set to 1, so a button already held when reset is released produces no strobe until it is released and pressed again.
- Reset asserted mid-hold or with a pop pending: the pending pop is discarded and no strobe is emitted afterwards.
- Counters never wrap, because every state clears its counter on reaching its terminal count.

## Test plan
Bench parameters: DELAY_CYCLES=4, REPEAT_CYCLES=2.

1. Single press: push_lvl 0→1 for 1 cycle with full=0 → one push pulse one cycle later; pop=0 and reject=0 throughout.
2. Hold: push_lvl held 12 cycles from edge t with full=0 → push pulses at t+1, t+5, t+7, t+9, t+11; release → no further pulses.
3. Blocking: full=1 with a push press → reject pulse only. empty=1 with a pop press → reject pulse only.
4. Collision: push_lvl and pop_lvl rise on the same edge t with full=0 and empty=1, and empty drops to 0 after the push → push at t+1, pop at t+2, no reject.
5. Reset: hold pop_lvl through assertion and release of reset → no pop strobe. Assert reset one cycle after a collision → the pending pop is never issued and all outputs read 0.
